// File: rtl/x1_multiplier.sv
// X1 stage of the multiplier: forms two 64-bit partial sums and queues them in a
// 2-entry X1X2 FIFO. Optional FLUSH_SX1 input when X1_MUL_FLUSH_EN is defined.
module x1_multiplier (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [31:0]  OP1_SE,
  input  logic [31:0]  OP2_SE,
  input  logic [1:0]   MUL_CMD_SE,
  input  logic         EX1_EMPTY_SE,
`ifdef X1_MUL_FLUSH_EN
  input  logic         FLUSH_SX1,
`endif
  output logic         EX1_POP_SX1,
  input  logic         X1X2_POP_SX2,
  output logic [127:0] RES_RX1,
  output logic         SELECT_MSB_RX1,
  output logic         SIGNED_RES_RX1,
  output logic         X1X2_EMPTY_SX1
);

  localparam logic [1:0] CMD_MUL    = 2'b00;
  localparam logic [1:0] CMD_MULH   = 2'b01;
  localparam logic [1:0] CMD_MULHSU = 2'b10;

  typedef struct packed {
    logic [63:0] p_hi;
    logic [63:0] p_lo;
    logic        select_msb;
    logic        signed_res;
  } entry_t;

  logic        a_signed;
  logic        b_signed;
  logic [63:0] a64;
  logic [63:0] b64;
  logic [63:0] p_lo;
  logic [31:0] p_hi_upper;
  entry_t      new_entry;

  assign a_signed = (MUL_CMD_SE == CMD_MULH) || (MUL_CMD_SE == CMD_MULHSU);
  assign b_signed = (MUL_CMD_SE == CMD_MULH);
  assign a64      = {{32{a_signed & OP1_SE[31]}}, OP1_SE};
  assign b64      = {{32{b_signed & OP2_SE[31]}}, OP2_SE};

  // The upper half of b64 only ever contributes to bits [63:32] of the product,
  // so a 32x32 product of the low multiplicand half is enough for P_hi.
  assign p_lo       = a64 * {32'h0, b64[31:0]};
  assign p_hi_upper = a64[31:0] * b64[63:32];

  assign new_entry.p_lo       = p_lo;
  assign new_entry.p_hi       = {p_hi_upper, 32'h0};
  assign new_entry.select_msb = (MUL_CMD_SE != CMD_MUL);
  assign new_entry.signed_res = a_signed;

  logic flush;
`ifdef X1_MUL_FLUSH_EN
  assign flush = FLUSH_SX1;
`else
  assign flush = 1'b0;
`endif

  entry_t     mem [2];
  logic [1:0] count;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       full;
  logic       push;
  logic       pop_eff;

  assign full = (count == 2'd2);

  // NOTE: reset_n gates the handshake combinationally so no operand is consumed
  // while reset is held, even with upstream presenting valid data.
  assign push    = reset_n & ~EX1_EMPTY_SE & ~full & ~flush;
  assign pop_eff = X1X2_POP_SX2 & (count != 2'd0) & ~flush;

  assign EX1_POP_SX1 = push;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      // NOTE: the storage is reset too, so the head outputs read as zero during reset.
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      mem[0] <= '0;
      mem[1] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= new_entry;
      end
      wr_ptr <= wr_ptr ^ push;
      rd_ptr <= rd_ptr ^ pop_eff;
      count  <= count + {1'b0, push} - {1'b0, pop_eff};
    end
  end

  entry_t head;
  assign head = mem[rd_ptr];

  assign RES_RX1        = {head.p_hi, head.p_lo};
  assign SELECT_MSB_RX1 = head.select_msb;
  assign SIGNED_RES_RX1 = head.signed_res;
  assign X1X2_EMPTY_SX1 = (count == 2'd0);

endmodule

// File: tb/tb_x1_multiplier.sv
// Randomised self-checking bench for x1_multiplier: a queue-based reference model
// predicts the handshake, FIFO occupancy and the 64-bit product per command.
module tb_x1_multiplier;

  logic         clk;
  logic         reset_n;
  logic [31:0]  op1;
  logic [31:0]  op2;
  logic [1:0]   cmd;
  logic         ex1_empty;
  logic         ex1_pop;
  logic         x2_pop;
  logic [127:0] res;
  logic         select_msb;
  logic         signed_res;
  logic         x1x2_empty;
`ifdef X1_MUL_FLUSH_EN
  logic         flush;
`endif

  x1_multiplier dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .OP1_SE         (op1),
    .OP2_SE         (op2),
    .MUL_CMD_SE     (cmd),
    .EX1_EMPTY_SE   (ex1_empty),
`ifdef X1_MUL_FLUSH_EN
    .FLUSH_SX1      (flush),
`endif
    .EX1_POP_SX1    (ex1_pop),
    .X1X2_POP_SX2   (x2_pop),
    .RES_RX1        (res),
    .SELECT_MSB_RX1 (select_msb),
    .SIGNED_RES_RX1 (signed_res),
    .X1X2_EMPTY_SX1 (x1x2_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] prod;
    logic        sel;
    logic        sgn;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Reference: the product the command asks for, computed with plain signed or
  // unsigned 64-bit arithmetic.
  function automatic exp_t ref_op(input logic [1:0] c, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa;
    longint sb;
    longint ua;
    longint ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    case (c)
      2'd0:    e.prod = 64'(ua * ub);
      2'd1:    e.prod = 64'(sa * sb);
      2'd2:    e.prod = 64'(sa * ub);
      default: e.prod = 64'(ua * ub);
    endcase
    e.sel = (c != 2'd0);
    e.sgn = (c == 2'd1) || (c == 2'd2);
    return e;
  endfunction

  // One clock: drive at posedge+1, check the handshake mid-cycle, advance the
  // model, then check the head at posedge+1 of the next cycle.
  task automatic cycle(input string tag, input logic vld, input logic [1:0] c,
                       input logic [31:0] a, input logic [31:0] b, input logic pop);
    logic        exp_push;
    logic        exp_pop;
    logic [63:0] sum;
    ex1_empty = ~vld;
    cmd       = c;
    op1       = a;
    op2       = b;
    x2_pop    = pop;
    #3;
    exp_push = vld && (q.size() < 2);
    exp_pop  = pop && (q.size() > 0);
    n_vec++;
    if (ex1_pop !== exp_push) begin
      n_err++;
      $display("FAIL %s ex1_pop: got %b want %b", tag, ex1_pop, exp_push);
    end
    if (exp_pop) void'(q.pop_front());
    if (exp_push) q.push_back(ref_op(c, a, b));
    @(posedge clk);
    #1;
    ex1_empty = 1'b1;
    x2_pop    = 1'b0;
    n_vec++;
    if (x1x2_empty !== (q.size() == 0)) begin
      n_err++;
      $display("FAIL %s empty: got %b want %b", tag, x1x2_empty, q.size() == 0);
    end
    if (q.size() > 0) begin
      sum = res[63:0] + res[127:64];
      n_vec++;
      if (sum !== q[0].prod || select_msb !== q[0].sel || signed_res !== q[0].sgn
          || res[95:64] !== 32'h0) begin
        n_err++;
        $display("FAIL %s head: got sum=%h sel=%b sgn=%b phi_lo=%h want sum=%h sel=%b sgn=%b phi_lo=0",
                 tag, sum, select_msb, signed_res, res[95:64], q[0].prod, q[0].sel, q[0].sgn);
      end
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 4 && q.size() > 0; i++) cycle("drain", 1'b0, 2'd0, 32'h0, 32'h0, 1'b1);
  endtask

  task automatic test_reset();
    ex1_empty = 1'b0;
    cmd       = 2'd3;
    op1       = 32'hFFFF_FFFF;
    op2       = 32'hFFFF_FFFF;
    x2_pop    = 1'b1;
    #2;
    n_vec++;
    if (x1x2_empty !== 1'b1 || res !== 128'h0 || select_msb !== 1'b0
        || signed_res !== 1'b0 || ex1_pop !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: got empty=%b res=%h sel=%b sgn=%b pop=%b want 1,0,0,0,0",
               x1x2_empty, res, select_msb, signed_res, ex1_pop);
    end
    ex1_empty = 1'b1;
    x2_pop    = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_directed();
    logic [63:0] sum;
    logic [1:0]  cmds [4] = '{2'd0, 2'd1, 2'd3, 2'd2};
    logic [31:0] as   [4] = '{32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bs   [4] = '{32'd5, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2};
    logic [63:0] sums [4] = '{64'd15, 64'h1, 64'hFFFF_FFFE_0000_0001, 64'hFFFF_FFFF_FFFF_FFFE};
    logic        sels [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic        sgns [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      cycle("directed", 1'b1, cmds[i], as[i], bs[i], 1'b0);
      sum = res[63:0] + res[127:64];
      n_vec++;
      if (sum !== sums[i] || select_msb !== sels[i] || signed_res !== sgns[i]) begin
        n_err++;
        $display("FAIL directed_%0d: got sum=%h sel=%b sgn=%b want sum=%h sel=%b sgn=%b",
                 i, sum, select_msb, signed_res, sums[i], sels[i], sgns[i]);
      end
      drain();
    end
  endtask

  task automatic test_full();
    cycle("full_1", 1'b1, 2'd0, 32'd7, 32'd9, 1'b0);
    cycle("full_2", 1'b1, 2'd3, 32'd11, 32'd13, 1'b0);
    cycle("full_3", 1'b1, 2'd1, 32'd17, 32'd19, 1'b0);
    cycle("full_pop", 1'b1, 2'd1, 32'd17, 32'd19, 1'b1);
    cycle("full_next", 1'b1, 2'd1, 32'd17, 32'd19, 1'b0);
    n_vec++;
    if (q.size() != 2 || x1x2_empty !== 1'b0) begin
      n_err++;
      $display("FAIL full_occupancy: got model=%0d empty=%b want model=2 empty=0", q.size(), x1x2_empty);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [63:0] sum;
    cycle("b2b_fill", 1'b1, 2'd3, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
    cycle("b2b_swap", 1'b1, 2'd0, 32'd100, 32'd200, 1'b1);
    sum = res[63:0] + res[127:64];
    n_vec++;
    if (x1x2_empty !== 1'b0 || sum !== 64'd20000 || select_msb !== 1'b0) begin
      n_err++;
      $display("FAIL b2b_head: got empty=%b sum=%h sel=%b want empty=0 sum=%h sel=0",
               x1x2_empty, sum, select_msb, 64'd20000);
    end
    drain();
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] b;
    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) b = 32'hFFFF_FFFF;
      cycle("random", $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), a, b,
            $urandom_range(0, 1) == 1);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    cycle("rst_fill1", 1'b1, 2'd1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1'b0);
    cycle("rst_fill2", 1'b1, 2'd2, 32'hCAFE_0001, 32'h0000_0003, 1'b0);
    ex1_empty = 1'b0;
    x2_pop    = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    n_vec++;
    if (x1x2_empty !== 1'b1 || res !== 128'h0 || ex1_pop !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid: got empty=%b res=%h pop=%b want empty=1 res=0 pop=0",
               x1x2_empty, res, ex1_pop);
    end
    q.delete();
    @(posedge clk);
    #1;
    n_vec++;
    if (x1x2_empty !== 1'b1 || res !== 128'h0) begin
      n_err++;
      $display("FAIL reset_hold: got empty=%b res=%h want empty=1 res=0", x1x2_empty, res);
    end
    ex1_empty = 1'b1;
    x2_pop    = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    cycle("post_reset", 1'b1, 2'd0, 32'd6, 32'd7, 1'b0);
    drain();
  endtask

`ifdef X1_MUL_FLUSH_EN
  task automatic test_flush();
    cycle("fl_fill1", 1'b1, 2'd0, 32'd2, 32'd3, 1'b0);
    cycle("fl_fill2", 1'b1, 2'd0, 32'd4, 32'd5, 1'b0);
    flush     = 1'b1;
    ex1_empty = 1'b0;
    x2_pop    = 1'b1;
    #3;
    n_vec++;
    if (ex1_pop !== 1'b0) begin
      n_err++;
      $display("FAIL flush_pop: got %b want 0", ex1_pop);
    end
    @(posedge clk);
    #1;
    flush     = 1'b0;
    ex1_empty = 1'b1;
    x2_pop    = 1'b0;
    q.delete();
    n_vec++;
    if (x1x2_empty !== 1'b1 || res !== 128'h0) begin
      n_err++;
      $display("FAIL flush_state: got empty=%b res=%h want empty=1 res=0", x1x2_empty, res);
    end
    cycle("post_flush", 1'b1, 2'd3, 32'd8, 32'd9, 1'b0);
    drain();
  endtask
`endif

  initial begin
    reset_n   = 1'b0;
    ex1_empty = 1'b1;
    x2_pop    = 1'b0;
    cmd       = 2'd0;
    op1       = 32'h0;
    op2       = 32'h0;
`ifdef X1_MUL_FLUSH_EN
    flush     = 1'b0;
`endif
    test_reset();
    test_directed();
    test_full();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef X1_MUL_FLUSH_EN
    test_flush();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/x1_multiplier.md
X1_MULTIPLIER -- requirements
Module: x1_multiplier

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: OP1_SE  input  32  multiplicand rs1.
REQ-004 SHALL have port: OP2_SE  input  32  multiplier rs2.
REQ-005 SHALL have port: MUL_CMD_SE  input  2  00=MUL, 01=MULH, 10=MULHSU, 11=MULHU.
REQ-006 SHALL have port: EX1_EMPTY_SE  input  1  upstream EXE->X1 FIFO empty; operands valid when 0.
REQ-007 SHALL have port: EX1_POP_SX1  output  1  consume current upstream operands.
REQ-008 SHALL have port: X1X2_POP_SX2  input  1  downstream pops head entry.
REQ-009 SHALL have port: RES_RX1  output  128  head entry partial sums: [63:0]=P_lo, [127:64]=P_hi.
REQ-010 SHALL have port: SELECT_MSB_RX1  output  1  head entry: 1 when cmd is not MUL.
REQ-011 SHALL have port: SIGNED_RES_RX1  output  1  head entry: 1 for MULH or MULHSU.
REQ-012 SHALL have port: X1X2_EMPTY_SX1  output  1  internal X1X2 FIFO empty.

Function
REQ-013 SHALL extend OP1 to 64-bit a64: sign-extend for MULH/MULHSU, zero-extend otherwise.
REQ-014 SHALL extend OP2 to 64-bit b64: sign-extend for MULH only, zero-extend otherwise.
REQ-015 SHALL compute P_lo = (a64 * {32'b0, b64[31:0]}) mod 2^64.
REQ-016 SHALL compute P_hi = ({a64[31:0] * b64[63:32]} mod 2^32) << 32, 64 bits.
REQ-017 SHALL guarantee (P_lo + P_hi) mod 2^64 equals the 64-bit product per command semantics.
REQ-018 SHALL hold a 2-entry X1X2 FIFO of {P_lo, P_hi, SELECT_MSB, SIGNED_RES}, 130 bits per entry.
REQ-019 SHALL assert EX1_POP_SX1 = !EX1_EMPTY_SE && !full, combinationally; a push occurs in exactly that cycle.
REQ-020 SHALL, when full, not push even if a pop occurs in the same cycle.
REQ-021 SHALL ignore X1X2_POP_SX2 while empty; count and pointers unchanged.
REQ-022 SHALL support simultaneous push and pop at count 1: count stays 1, head advances to new entry.
REQ-023 SHALL present the head entry on RES_RX1/SELECT_MSB_RX1/SIGNED_RES_RX1 combinationally from storage; latency push-to-visible is 1 cycle.
REQ-024 SHALL wrap 1-bit read/write pointers modulo 2; count is 2 bits, 0..2.
REQ-025 SHALL drive X1X2_EMPTY_SX1 = (count == 0).

Reset
REQ-026 SHALL on reset_n low clear count, pointers and all entry storage to 0, asynchronously.
REQ-027 SHALL hold outputs during reset: RES_RX1=0, SELECT_MSB_RX1=0, SIGNED_RES_RX1=0, X1X2_EMPTY_SX1=1, EX1_POP_SX1=0.
REQ-028 SHALL discard any in-flight entry when reset asserts mid-operation; no pop or push is honoured until reset_n is high at a rising edge.

Configuration
REQ-029 SHALL, with macro X1_MUL_FLUSH_EN defined, add input FLUSH_SX1 (1 bit); when high at a rising edge, count and pointers clear to 0, push and pop that cycle are dropped, and EX1_POP_SX1 is forced 0.
REQ-030 SHALL, without X1_MUL_FLUSH_EN, have no FLUSH_SX1 port and no flush behaviour.

Verification
REQ-031 SHALL cover: MUL 3*5 -> RES_RX1[63:0]+RES_RX1[127:64] mod 2^64 = 15, SELECT_MSB=0, SIGNED=0.
REQ-032 SHALL cover: MULH 0xFFFFFFFF*0xFFFFFFFF -> sum = 0x0000000000000001, SELECT_MSB=1, SIGNED=1.
REQ-033 SHALL cover: MULHU 0xFFFFFFFF*0xFFFFFFFF -> sum = 0xFFFFFFFE00000001; MULHSU 0xFFFFFFFF*2 -> sum = 0xFFFFFFFFFFFFFFFE.
REQ-034 SHALL cover: three ops, no downstream pop -> EX1_POP_SX1 low on the third; a pop at full accepts no push that cycle; the next cycle pushes.
REQ-035 SHALL cover: count 1 with simultaneous push and pop -> EMPTY stays 0, head shows new op the next cycle.
REQ-036 SHALL cover: reset_n low with 2 entries held -> EMPTY=1 immediately, RES_RX1=0; with X1_MUL_FLUSH_EN, FLUSH_SX1 gives the same state at the next edge.
